// File: rtl/key_pkg.sv
// Shared types and helpers for the key debounce front end.
// No logic of its own; imported by the top level.
// One-hot test works on the debounced vector, not the raw lines.
package key_pkg;

    localparam int NKEYS = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        VALID    = 2'd1,
        WAIT_REL = 2'd2
    } key_state_t;

    function automatic logic is_onehot(input logic [NKEYS-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for one asynchronous input bit.
// Latency: 2 clk edges from input sample to q.
// Backpressure: none, free-running.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_debounce_onehot.sv
// Conditions four raw key lines into a held one-hot capture with valid/ack.
// Latency: valid rises DEBOUNCE_CYCLES+3 edges after key_in is first sampled.
// Backpressure: capture held until ack; no new press until a full release.
module key_debounce_onehot
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NKEYS-1:0] key_in,
    input  logic             ack,
    output logic [NKEYS-1:0] d_out,
    output logic             valid,
    output logic             multi_err
);

    localparam int              CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic [NKEYS-1:0] s;
    logic [NKEYS-1:0] prev;
    logic [CW-1:0]    cnt;
    logic             stable;
    logic [NKEYS-1:0] deb;
    key_state_t       state;

    for (genvar i = 0; i < NKEYS; i++) begin : g_sync
        sync_2ff u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (key_in[i]),
            .q     (s[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= '0;
            cnt  <= '0;
        end else begin
            prev <= s;
            if (s != prev) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // The FSM acts on prev: once cnt saturates, prev is the value that has been
    // steady for the whole window, whereas s may have just glitched this cycle.
    assign stable = (cnt == CNT_MAX);
    assign deb    = prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            d_out     <= '0;
            valid     <= 1'b0;
            multi_err <= 1'b0;
        end else begin
            multi_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (stable && (deb != '0)) begin
                        if (is_onehot(deb)) begin
                            d_out <= deb;
                            valid <= 1'b1;
                            state <= VALID;
                        end else begin
                            multi_err <= 1'b1;
                            state     <= WAIT_REL;
                        end
                    end
                end
                VALID: begin
                    if (ack) begin
                        d_out <= '0;
                        valid <= 1'b0;
                        state <= WAIT_REL;
                    end
                end
                WAIT_REL: begin
                    if (stable && (deb == '0)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_debounce_onehot.sv
// Scoreboarded bench: a windowed reference model queues expected events,
// an independent monitor pops them as the DUT raises valid/clears/multi_err.
module tb_key_debounce_onehot;

    localparam int DC = 4;
    localparam int EV_CAP = 0;
    localparam int EV_ERR = 1;
    localparam int EV_CLR = 2;
    localparam int S_IDLE = 0;
    localparam int S_HOLD = 1;
    localparam int S_WAIT = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] key_in = 4'b0000;
    logic       ack = 1'b0;
    logic [3:0] d_out;
    logic       valid;
    logic       multi_err;

    always #5 clk = ~clk;

    key_debounce_onehot #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_in    (key_in),
        .ack       (ack),
        .d_out     (d_out),
        .valid     (valid),
        .multi_err (multi_err)
    );

    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void chk(input bit ok, input string name, input int act, input int exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endfunction

    typedef struct {
        int kind;
        int dat;
        int cyc;
    } ev_t;

    ev_t        exp_q[$];
    logic [3:0] k_hist[$];   // key value sampled at each post-reset edge
    int         m_state = S_IDLE;

    // Synchronised view seen just before edge j: key sampled two edges earlier.
    function automatic logic [3:0] x_at(input int j);
        if (j < 2) return 4'b0000;
        return k_hist[j-2];
    endfunction

    task automatic push_ev(input int kind, input int dat, input int tag);
        ev_t e;
        e.kind = kind;
        e.dat  = dat;
        e.cyc  = tag;
        exp_q.push_back(e);
    endtask

    // A vector counts as settled once DC+1 consecutive synchronised samples agree.
    task automatic model_step(input logic [3:0] k, input logic a, input int tag);
        int         t;
        bit         st;
        logic [3:0] deb;
        t   = k_hist.size();
        deb = x_at(t - 1);
        st  = (t >= DC);
        for (int j = t - DC - 1; j < t - 1; j++)
            if (x_at(j) != deb) st = 0;
        case (m_state)
            S_IDLE: if (st && deb != 4'b0000) begin
                if ($countones(deb) == 1) begin
                    push_ev(EV_CAP, int'(deb), tag);
                    m_state = S_HOLD;
                end else begin
                    push_ev(EV_ERR, 0, tag);
                    m_state = S_WAIT;
                end
            end
            S_HOLD: if (a) begin
                push_ev(EV_CLR, 0, tag);
                m_state = S_WAIT;
            end
            default: if (st && deb == 4'b0000) m_state = S_IDLE;
        endcase
        k_hist.push_back(k);
    endtask

    task automatic model_reset();
        k_hist.delete();
        exp_q.delete();
        m_state = S_IDLE;
    endtask

    task automatic drive(input logic [3:0] k, input logic a);
        key_in = k;
        ack    = a;
        model_step(k, a, cyc + 1);
    endtask

    task automatic step(input logic [3:0] k, input logic a);
        @(negedge clk);
        drive(k, a);
    endtask

    task automatic mon_event(input int kind, input int dat);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk(0, "unexpected_event", kind, -1);
        end else begin
            e = exp_q.pop_front();
            chk(e.kind == kind, "event_kind", kind, e.kind);
            chk(e.cyc == cyc, "event_cycle", cyc, e.cyc);
            if (kind == EV_CAP) chk(dat == e.dat, "capture_data", dat, e.dat);
        end
    endtask

    logic       v_q;
    logic [3:0] d_q;
    initial begin
        v_q = 1'b0;
        d_q = 4'b0000;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                v_q = 1'b0;
                d_q = 4'b0000;
            end else begin
                while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    chk(0, "missed_event", -1, exp_q[0].kind);
                    void'(exp_q.pop_front());
                end
                if (valid && !v_q) mon_event(EV_CAP, int'(d_out));
                if (!valid && v_q) mon_event(EV_CLR, 0);
                if (multi_err)     mon_event(EV_ERR, 0);
                if (!valid)   chk(d_out == 4'b0000, "d_out_zero_when_invalid", d_out, 0);
                else if (v_q) chk(d_out == d_q, "d_out_hold", d_out, d_q);
                v_q = valid;
                d_q = d_out;
            end
        end
    end

    function automatic int enc(input logic [3:0] d);
        case (d)
            4'b0001: return 0;
            4'b0010: return 1;
            4'b0100: return 2;
            4'b1000: return 3;
            default: return -1;
        endcase
    endfunction

    // e0 is the edge that first sampled k; valid must appear DC+3 edges later.
    task automatic wait_valid(input logic [3:0] k, input int e0, input string name);
        bit seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (valid) begin
                seen = 1;
                chk(cyc - e0 == DC + 3, {name, "_latency"}, cyc - e0, DC + 3);
                chk(d_out == k, {name, "_d_out"}, d_out, k);
            end
            drive(k, 1'b0);
        end
        if (!seen) chk(0, {name, "_timeout"}, 0, 1);
    endtask

    task automatic press_measure(input logic [3:0] k, input string name);
        int e0;
        @(negedge clk);
        e0 = cyc + 1;
        drive(k, 1'b0);
        wait_valid(k, e0, name);
    endtask

    task automatic idle_zeros(input int n);
        for (int i = 0; i < n; i++) step(4'b0000, 1'b0);
    endtask

    initial begin
        int e0;
        #1;
        chk(valid == 1'b0, "reset_valid", valid, 0);
        chk(d_out == 4'b0000, "reset_d_out", d_out, 0);
        chk(multi_err == 1'b0, "reset_multi_err", multi_err, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drive(4'b0000, 1'b0);
        idle_zeros(8);

        // Clean press, then ack while still held and release
        press_measure(4'b0100, "clean_press");
        chk(enc(d_out) == 2, "encoder_value", enc(d_out), 2);
        step(4'b0100, 1'b1);
        idle_zeros(8);

        // Bounce: 2-cycle toggles never capture
        for (int i = 0; i < 20; i++)
            step(((i / 2) % 2 == 0) ? 4'b0010 : 4'b0000, 1'b0);
        chk(valid == 1'b0, "bounce_no_valid", valid, 0);
        press_measure(4'b0010, "bounce_final");
        step(4'b0010, 1'b1);
        idle_zeros(8);

        // Handshake with late ack after release
        press_measure(4'b1000, "handshake");
        idle_zeros(10);
        chk(valid == 1'b1, "held_after_release_valid", valid, 1);
        chk(d_out == 4'b1000, "held_after_release_d_out", d_out, 8);
        step(4'b0000, 1'b1);
        @(negedge clk);
        chk(valid == 1'b0, "ack_clears_valid", valid, 0);
        chk(d_out == 4'b0000, "ack_clears_d_out", d_out, 0);
        drive(4'b0000, 1'b0);
        idle_zeros(6);
        press_measure(4'b0100, "rearm_after_ack");
        step(4'b0100, 1'b1);
        idle_zeros(8);

        // Multi-key then a single key without full release
        for (int i = 0; i < 12; i++) step(4'b0011, 1'b0);
        for (int i = 0; i < 12; i++) step(4'b0001, 1'b0);
        chk(valid == 1'b0, "multi_then_single_no_valid", valid, 0);
        idle_zeros(8);

        // No re-trigger while held across ack
        press_measure(4'b0001, "retrigger_first");
        step(4'b0001, 1'b1);
        for (int i = 0; i < 15; i++) step(4'b0001, 1'($urandom_range(0, 1)));
        chk(valid == 1'b0, "held_no_retrigger", valid, 0);
        idle_zeros(6);
        press_measure(4'b0001, "retrigger_second");
        step(4'b0001, 1'b1);
        idle_zeros(8);

        // Asynchronous reset while valid, key still held at deassert
        press_measure(4'b1000, "pre_reset");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk(valid == 1'b0, "async_reset_valid", valid, 0);
        chk(d_out == 4'b0000, "async_reset_d_out", d_out, 0);
        chk(multi_err == 1'b0, "async_reset_multi_err", multi_err, 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        e0 = cyc + 1;
        drive(4'b1000, 1'b0);
        wait_valid(4'b1000, e0, "post_reset");
        step(4'b1000, 1'b1);
        idle_zeros(8);

        // Randomised segments
        for (int seg = 0; seg < 400; seg++) begin
            int         r;
            int         len;
            logic [3:0] v;
            r = $urandom_range(0, 9);
            if (r < 4) v = 4'b0000;
            else if (r < 8) v = 4'(1 << $urandom_range(0, 3));
            else begin
                do v = 4'($urandom_range(3, 15)); while ($countones(v) < 2);
            end
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) step(v, ($urandom_range(0, 3) == 0));
        end

        for (int i = 0; i < 20; i++) step(4'b0000, 1'b1);
        @(negedge clk);
        chk(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
